spi_flash_responder: RTL and testbench

- Synthesizable SPI serial-flash responder: the device end of the flash read link used by the sound subsystem.
- Decodes READ (0x03) and READ STATUS (0x05) commands from an SPI initiator and streams bytes from a local byte-wide memory port on MISO.
- Used as the on-board flash stand-in for playback data and as the DUT-facing model in flash-controller benches.
- Samples SCK/CS_n/MOSI with the system clock; no SCK-domain logic.

---
 rtl/spi_flash_responder_pkg.sv | 18 +
 rtl/spi_flash_responder_in_sync.sv | 37 +++
 rtl/spi_flash_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_responder_pkg.sv
// Shared definitions for the SPI serial-flash responder.
//   - Supported opcodes: READ (0x03) and READ STATUS (0x05).
//   - Transaction state encoding used by the responder FSM.
package spi_flash_responder_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDSR = 8'h05;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StStatus,
        StIgnore
    } state_e;

endpackage

// File: rtl/spi_flash_responder_in_sync.sv
// Input synchronizer with rise/fall detection for one SPI control line.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   din   asynchronous input (sck or cs_n)
//   dout  synchronized level
//   rise  one-cycle pulse on a synchronized 0->1 transition
//   fall  one-cycle pulse on a synchronized 1->0 transition
module spi_in_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI serial-flash responder (mode 0). Decodes READ (0x03) and READ STATUS
// (0x05), streams memory bytes or a status byte on miso. All SPI inputs are
// sampled with the system clock.
// Ports:
//   clk, rst         system clock, asynchronous active-low reset
//   cs_n, sck, mosi  SPI inputs from the initiator
//   miso             SPI data out, MSB first
//   mem_addr, mem_rd byte read request (one-cycle strobe)
//   mem_rdata        read data, qualified by mem_valid
//   mem_valid        one-cycle read-data valid
//   busy             transaction selected
//   cmd_err          one-cycle pulse on an unsupported opcode
//   underrun         sticky; a data byte was missing at its shift-out boundary
// ADDR_W must not exceed 24 (the address phase is always 24 bits).
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 24,
    parameter logic [7:0]  STATUS_VAL  = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_valid,
    output logic              busy,
    output logic              cmd_err,
    output logic              underrun
);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sck),
        .dout (sck_s),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cs_n),
        .dout (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // CS high is handled by level, and only sck edges matter.
    logic unused_sync;
    assign unused_sync = sck_s ^ cs_rise;

    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    state_e            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [23:0]       shift_in;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              mem_rd_q, mem_rd_d;
    logic              cmd_err_q, cmd_err_d;
    logic              underrun_q, underrun_d;
    // pend counts reads issued but not yet answered; skip counts answers that
    // belong to abandoned slots (underrun or aborted transaction) and are dropped.
    logic [2:0]        pend_q, pend_d;
    logic [2:0]        skip_q, skip_d;
    logic              slot_valid;

    assign shift_in   = {shift_q[22:0], mosi_s};
    assign slot_valid = mem_valid && (skip_q == 3'd0);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        mem_rd_d   = 1'b0;
        cmd_err_d  = 1'b0;
        underrun_d = underrun_q;
        pend_d     = pend_q + 3'(mem_rd_q) - 3'(mem_valid);
        skip_d     = skip_q;

        if (mem_valid && (skip_q != 3'd0)) begin
            skip_d = skip_q - 3'd1;
        end

        if (cs_s) begin
            state_d    = StIdle;
            bit_cnt_d  = 5'd0;
            tx_d       = 8'h00;
            buf_full_d = 1'b0;
            skip_d     = pend_d;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d   = StCmd;
                        bit_cnt_d = 5'd0;
                        shift_d   = 24'd0;
                    end
                end

                StCmd: begin
                    if (sck_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            if (shift_in[7:0] == OP_READ) begin
                                state_d = StAddr;
                            end else if (shift_in[7:0] == OP_RDSR) begin
                                state_d = StStatus;
                            end else begin
                                state_d   = StIgnore;
                                cmd_err_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end

                StAddr: begin
                    if (sck_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == 5'd23) begin
                            addr_d     = shift_in[ADDR_W-1:0];
                            mem_rd_d   = 1'b1;
                            state_d    = StData;
                            bit_cnt_d  = 5'd0;
                            buf_full_d = 1'b0;
                            tx_d       = 8'h00;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end

                StData, StStatus: begin
                    if (sck_fall) begin
                        // Count 0 marks the byte boundary (including the first
                        // fall after entry).
                        if (bit_cnt_q[2:0] == 3'd0) begin
                            if (state_q == StStatus) begin
                                tx_d = STATUS_VAL;
                            end else begin
                                buf_full_d = 1'b0;
                                addr_d     = addr_q + ADDR_W'(1);
                                mem_rd_d   = 1'b1;
                                if (buf_full_q) begin
                                    tx_d = buf_q;
                                end else begin
                                    tx_d       = 8'h00;
                                    underrun_d = 1'b1;
                                    // Data for this slot arriving now is simply
                                    // dropped; if still outstanding, drop it later.
                                    if (!slot_valid) begin
                                        skip_d = skip_d + 3'd1;
                                    end
                                end
                            end
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                        bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
                    end else if ((state_q == StData) && slot_valid) begin
                        buf_d      = mem_rdata;
                        buf_full_d = 1'b1;
                    end
                end

                StIgnore: begin
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 5'd0;
            shift_q    <= 24'd0;
            addr_q     <= '0;
            tx_q       <= 8'h00;
            buf_q      <= 8'h00;
            buf_full_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            underrun_q <= 1'b0;
            pend_q     <= 3'd0;
            skip_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            mem_rd_q   <= mem_rd_d;
            cmd_err_q  <= cmd_err_d;
            underrun_q <= underrun_d;
            pend_q     <= pend_d;
            skip_q     <= skip_d;
        end
    end

    assign miso     = ((state_q == StData) || (state_q == StStatus)) ? tx_q[7] : 1'b0;
    assign mem_addr = addr_q;
    assign mem_rd   = mem_rd_q;
    assign busy     = (state_q != StIdle);
    assign cmd_err  = cmd_err_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI initiator tasks (sck = clk/16),
// a latency-programmable byte memory where byte[a] = a[7:0], and immediate
// assertions at every comparison point.
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_valid = 1'b0;
    logic        busy;
    logic        cmd_err;
    logic        underrun;

    always #5 clk = ~clk;

    spi_flash_responder #(
        .ADDR_W      (24),
        .STATUS_VAL  (8'hA5),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .busy      (busy),
        .cmd_err   (cmd_err),
        .underrun  (underrun)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          due;
        logic [23:0] addr;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [23:0] rd_log[$];
    int          cyc = 0;
    bit          slow_mode = 1'b0;
    int          cmd_err_cnt = 0;
    int          miso_hi_cnt = 0;
    logic [7:0]  rx[8];

    // In-order memory model; in slow mode every read after the first of a
    // transaction takes 200 cycles.
    always @(negedge clk) begin
        int lat;
        cyc++;
        if (mem_rd === 1'b1) begin
            lat = (slow_mode && rd_log.size() > 0) ? 200 : 2;
            rd_log.push_back(mem_addr);
            rsp_q.push_back('{cyc + lat, mem_addr});
        end
        if (cmd_err === 1'b1) cmd_err_cnt++;
        if (miso === 1'b1) miso_hi_cnt++;
        mem_valid = 1'b0;
        mem_rdata = 8'h00;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mem_valid = 1'b1;
            mem_rdata = rsp_q[0].addr[7:0];
            void'(rsp_q.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        sck  = 1'b0;
        mosi = b;
        wait_clk(8);
        sck = 1'b1;
        wait_clk(4);
        r = miso;
        wait_clk(4);
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], x);
            r[i] = x;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        rd_log.delete();
        cmd_err_cnt = 0;
        miso_hi_cnt = 0;
        cs_n = 1'b0;
    endtask

    task automatic cs_end();
        cs_n = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        wait_clk(16);
    endtask

    task automatic read_txn(input logic [23:0] a, input int n);
        logic [7:0] r;
        cs_begin();
        spi_byte(8'h03, r);
        spi_byte(a[23:16], r);
        spi_byte(a[15:8], r);
        spi_byte(a[7:0], r);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, r);
            rx[i] = r;
        end
        cs_end();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] wrap_addr[4];
        logic [7:0]  wrap_data[4];
        logic [7:0]  r;
        logic        b;

        rst  = 1'b0;
        cs_n = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        wait_clk(3);
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_mem_rd", 32'(mem_rd), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cmd_err", 32'(cmd_err), 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);
        rst = 1'b1;
        wait_clk(4);

        // Contiguous READ from 0x000010
        read_txn(24'h000010, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("read_data%0d", i), 32'(rx[i]), 32'h10 + i);
        chk("read_rd_count", rd_log.size(), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("read_addr%0d", i), 32'(rd_log[i]), 32'h10 + i);
        chk("read_underrun", 32'(underrun), 32'd0);
        chk("read_busy_after", 32'(busy), 32'd0);

        // Address wrap
        wrap_addr[0] = 24'hFFFFFE; wrap_addr[1] = 24'hFFFFFF;
        wrap_addr[2] = 24'h000000; wrap_addr[3] = 24'h000001;
        wrap_data[0] = 8'hFE; wrap_data[1] = 8'hFF; wrap_data[2] = 8'h00; wrap_data[3] = 8'h01;
        read_txn(24'hFFFFFE, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_addr%0d", i), 32'(rd_log[i]), 32'(wrap_addr[i]));
            chk($sformatf("wrap_data%0d", i), 32'(rx[i]), 32'(wrap_data[i]));
        end

        // READ STATUS
        cs_begin();
        spi_byte(8'h05, r);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'h00, r);
            chk($sformatf("status_byte%0d", i), 32'(r), 32'hA5);
        end
        cs_end();
        chk("status_no_mem_rd", rd_log.size(), 32'd0);
        chk("status_cmd_err", cmd_err_cnt, 32'd0);

        // Unsupported opcode
        cs_begin();
        spi_byte(8'h9F, r);
        spi_byte(8'hFF, r);
        chk("badop_miso_byte1", 32'(r), 32'd0);
        spi_byte(8'hFF, r);
        chk("badop_miso_byte2", 32'(r), 32'd0);
        chk("badop_cmd_err_pulses", cmd_err_cnt, 32'd1);
        chk("badop_miso_high_cycles", miso_hi_cnt, 32'd0);
        chk("badop_busy_selected", 32'(busy), 32'd1);
        cs_end();
        chk("badop_busy_released", 32'(busy), 32'd0);

        // Abort after 12 address bits, then a full READ
        cs_begin();
        spi_byte(8'h03, r);
        for (int i = 0; i < 12; i++) spi_bit(1'(i % 2), b);
        chk("abort_busy_mid", 32'(busy), 32'd1);
        cs_end();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_mem_rd", rd_log.size(), 32'd0);
        read_txn(24'h000020, 1);
        chk("after_abort_data", 32'(rx[0]), 32'h20);
        chk("after_abort_addr", 32'(rd_log[0]), 32'h20);

        // Memory slower than a byte after the first fetch
        slow_mode = 1'b1;
        read_txn(24'h000040, 2);
        chk("slow_first_byte", 32'(rx[0]), 32'h40);
        chk("slow_second_byte", 32'(rx[1]), 32'h00);
        chk("slow_underrun", 32'(underrun), 32'd1);
        wait_clk(500);
        slow_mode = 1'b0;
        read_txn(24'h000050, 2);
        chk("post_slow_byte0", 32'(rx[0]), 32'h50);
        chk("post_slow_byte1", 32'(rx[1]), 32'h51);
        chk("underrun_sticky", 32'(underrun), 32'd1);

        // Async reset in the middle of DATA
        cs_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        spi_byte(8'hF0, r);
        spi_byte(8'h00, r);
        chk("mid_data_byte0", 32'(r), 32'hF0);
        sck  = 1'b0;
        mosi = 1'b0;
        wait_clk(6);
        chk("mid_data_miso", 32'(miso), 32'd1);
        chk("mid_data_busy", 32'(busy), 32'd1);
        chk("mid_data_addr", 32'(mem_addr), 32'hF2);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_miso", 32'(miso), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("async_rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("async_rst_cmd_err", 32'(cmd_err), 32'd0);
        chk("async_rst_underrun", 32'(underrun), 32'd0);
        cs_n = 1'b1;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
